// File: rtl/obi_sram_device_if.sv
// OBI-style request/response bus between a host (master) and the SRAM device (slave).
// Signal names carry the device-side _i/_o direction suffixes.
interface obi_sram_device_if;
   logic        req_i;
   logic        we_i;
   logic [7:0]  be_i;
   logic [63:0] addr_i;
   logic [63:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [63:0] rdata_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/obi_sram_device.sv
// 64-bit OBI SRAM device with byte-enabled writes and a single outstanding read.
// Define OBI_DEV_WAIT_STATES_EN to insert WAIT_CYCLES read wait states.
module obi_sram_device #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   obi_sram_device_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   if (DEPTH_WORDS < 2 || DEPTH_WORDS > 65536 ||
       (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("obi_sram_device: DEPTH_WORDS must be a power of two in 2..65536");
   end

`ifdef OBI_DEV_WAIT_STATES_EN
   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("obi_sram_device: WAIT_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;
`else
   localparam int unsigned unused_wait_cycles = WAIT_CYCLES;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd2
   } state_e;
`endif

   state_e            state_q, state_d;
   logic [63:0]       mem_q [DEPTH_WORDS];
   logic [63:0]       rdata_q, rdata_d;
   logic [AW-1:0]     widx;
   logic              gnt;
   logic              rd_gnt;
   logic              wr_gnt;
   logic              unused_addr;

`ifdef OBI_DEV_WAIT_STATES_EN
   logic [3:0]        cnt_q, cnt_d;
   logic [63:0]       rbuf_q;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
`endif

   assign widx        = bus.addr_i[AW+2:3];
   assign unused_addr = ^{bus.addr_i[63:AW+3], bus.addr_i[2:0]};

`ifdef OBI_DEV_WAIT_STATES_EN
   assign gnt = bus.req_i && !rst_i && (state_q != S_WAIT);
`else
   assign gnt = bus.req_i && !rst_i;
`endif
   assign rd_gnt = gnt && !bus.we_i;
   assign wr_gnt = gnt &&  bus.we_i;

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = (state_q == S_RESP);
   assign bus.rdata_o  = rdata_q;

   // Storage is never reset; writes are gated by gnt, which is low during reset.
   always_ff @(posedge clk_i) begin
      if (wr_gnt) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (bus.be_i[b]) begin
               mem_q[widx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
            end
         end
      end
   end

`ifdef OBI_DEV_WAIT_STATES_EN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (rd_gnt) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               rdata_d = rbuf_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rd_gnt) begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The word is sampled at grant into rbuf_q but only exposed on entry to RESP,
   // so rdata_o keeps the previous response throughout WAIT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (rd_gnt) begin
            rbuf_q <= mem_q[widx];
         end
      end
   end
`else
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      if (rd_gnt) rdata_d = mem_q[widx];
      case (state_q)
         S_IDLE:  if (rd_gnt) state_d = S_RESP;
         S_RESP:  state_d = rd_gnt ? S_RESP : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end
`endif

endmodule

// File: tb/tb_obi_sram_device.sv
// Self-checking bench for obi_sram_device: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_obi_sram_device;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WAITC = 2;
`ifdef OBI_DEV_WAIT_STATES_EN
   localparam int unsigned LAT = WAITC + 1;
`else
   localparam int unsigned LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   obi_sram_device_if bus();

   obi_sram_device #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Model: word array plus at most one pending read with the cycle its response is due.
   logic [63:0] mem_m [DEPTH];
   logic        pend_v;
   int unsigned pend_due;
   logic [63:0] pend_d;
   logic [63:0] last_d;
   int unsigned cyc;

   typedef struct {
      logic [63:0] waddr;
      logic [63:0] wdata;
      logic [7:0]  wbe;
      logic [63:0] raddr;
      logic [63:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
      end
   endtask

   function automatic int unsigned widx(input logic [63:0] a);
      logic [63:0] w;
      w = (a >> 3) % 64'(DEPTH);
      return w[31:0];
   endfunction

   task automatic drive(input logic r, input logic w, input logic [7:0] b,
                        input logic [63:0] a, input logic [63:0] d);
      bus.req_i   = r;
      bus.we_i    = w;
      bus.be_i    = b;
      bus.addr_i  = a;
      bus.wdata_i = d;
   endtask

   // One clock cycle: compare outputs to the model mid-cycle, then advance the model at the edge.
   task automatic step(output logic g, output logic v, output logic [63:0] d);
      logic        eg, ev;
      logic [63:0] ed;
      int unsigned ix;
      @(negedge clk);
      ev = pend_v && (pend_due == cyc);
      ed = ev ? pend_d : last_d;
      eg = bus.req_i && (!pend_v || pend_due == cyc);
      g  = bus.gnt_o;
      v  = bus.rvalid_o;
      d  = bus.rdata_o;
      chk("gnt", 64'(g), 64'(eg));
      chk("rvalid", 64'(v), 64'(ev));
      chk("rdata", d, ed);
      @(posedge clk);
      if (ev) begin
         last_d = pend_d;
         pend_v = 1'b0;
      end
      if (eg) begin
         ix = widx(bus.addr_i);
         if (bus.we_i) begin
            for (int b = 0; b < 8; b++)
               if (bus.be_i[b]) mem_m[ix][8*b +: 8] = bus.wdata_i[8*b +: 8];
         end else begin
            pend_v   = 1'b1;
            pend_due = cyc + LAT;
            pend_d   = mem_m[ix];
         end
      end
      cyc++;
      #1;
   endtask

   task automatic issue(input string name, input logic w, input logic [7:0] b,
                        input logic [63:0] a, input logic [63:0] d, output int unsigned waits);
      logic        g, v;
      logic [63:0] q;
      drive(1'b1, w, b, a, d);
      waits = 0;
      g = 1'b0;
      for (int k = 0; k < 32 && !g; k++) begin
         step(g, v, q);
         if (!g) waits++;
      end
      if (!g) chk({name, " gnt timeout"}, 64'(g), 64'd1);
      drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
   endtask

   task automatic wait_resp(input string name, output int unsigned lat, output logic [63:0] data);
      logic g, v;
      lat  = 0;
      v    = 1'b0;
      data = '0;
      for (int k = 0; k < 32 && !v; k++) begin
         step(g, v, data);
         lat++;
      end
      chk({name, " rvalid seen"}, 64'(v), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vt[8];
      int unsigned waits, lat, ng, nv;
      int unsigned g_c[2], rv_c[2];
      logic [63:0] rv_d[2];
      logic [63:0] data, a;
      logic        g, v;
      logic [7:0]  b;
      int unsigned pool;

      vt[0] = '{64'h10,   64'h1122334455667788, 8'hFF, 64'h10,                 64'h1122334455667788};
      vt[1] = '{64'h18,   64'h0,                8'hFF, 64'h18,                 64'h0};
      vt[2] = '{64'h18,   64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h18,                 64'h00000000FFFFFFFF};
      vt[3] = '{64'h2000, 64'hA5,               8'hFF, 64'h0,                  64'hA5};
      vt[4] = '{64'h10,   64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h10,                 64'h1122334455667788};
      vt[5] = '{64'h1FF8, 64'h0123456789ABCDEF, 8'hFF, 64'h1FF8,               64'h0123456789ABCDEF};
      vt[6] = '{64'h1FFF, 64'hFF00000000000000, 8'h80, 64'hFFFFFFFFFFFFFFF8,   64'hFF23456789ABCDEF};
      vt[7] = '{64'h0,    64'hDEADDEADDEADDEAD, 8'h00, 64'hFFFFFFFFFFFFE007,   64'hA5};

      for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;

      // Asynchronous reset takes effect before any clock edge.
      drive(1'b1, 1'b0, 8'h00, 64'h0, 64'h0);
      #1 rst = 1'b1;
      #1;
      chk("reset gnt", 64'(bus.gnt_o), 64'd0);
      chk("reset rvalid", 64'(bus.rvalid_o), 64'd0);
      chk("reset rdata", bus.rdata_o, 64'h0);
      drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      cyc = 0; pend_v = 1'b0; pend_due = 0; pend_d = '0; last_d = '0;

      // Directed vectors: write, then read-after-write in the very next cycle.
      foreach (vt[i]) begin
         issue("vec write", 1'b1, vt[i].wbe, vt[i].waddr, vt[i].wdata, waits);
         issue("vec read", 1'b0, 8'h00, vt[i].raddr, 64'h0, waits);
         chk("vec read gnt same cycle", 64'(waits), 64'd0);
         wait_resp("vec read", lat, data);
         chk("vec latency", 64'(lat), 64'(LAT));
         chk("vec rdata", data, vt[i].exp);
      end

      // Back-to-back reads with req held.
      issue("b2b preload", 1'b1, 8'hFF, 64'h8, 64'hCAFEF00DDEADBEEF, waits);
      drive(1'b1, 1'b0, 8'h00, 64'h0, 64'h0);
      ng = 0; nv = 0;
      g_c = '{0, 0}; rv_c = '{0, 0}; rv_d = '{64'h0, 64'h0};
      for (int k = 0; k < 40 && nv < 2; k++) begin
         step(g, v, data);
         if (v) begin
            rv_c[nv] = k; rv_d[nv] = data; nv++;
         end
         if (g && ng < 2) begin
            g_c[ng] = k; ng++;
            if (ng == 1) bus.addr_i = 64'h8;
            else bus.req_i = 1'b0;
         end
      end
      drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
      chk("b2b gnt count", 64'(ng), 64'd2);
      chk("b2b rvalid count", 64'(nv), 64'd2);
      chk("b2b second gnt in first resp", 64'(g_c[1]), 64'(rv_c[0]));
      chk("b2b gnt spacing", 64'(g_c[1] - g_c[0]), 64'(LAT));
      chk("b2b rvalid spacing", 64'(rv_c[1] - rv_c[0]), 64'(LAT));
      chk("b2b data0", rv_d[0], 64'hA5);
      chk("b2b data1", rv_d[1], 64'hCAFEF00DDEADBEEF);

      // Reset while a read is pending; a write held across the reset edge must not land.
      issue("rst read", 1'b0, 8'h00, 64'h10, 64'h0, waits);
      drive(1'b1, 1'b1, 8'hFF, 64'h10, 64'h0);
      #2 rst = 1'b1;
      #1;
      chk("mid-read reset gnt", 64'(bus.gnt_o), 64'd0);
      chk("mid-read reset rvalid", 64'(bus.rvalid_o), 64'd0);
      chk("mid-read reset rdata", bus.rdata_o, 64'h0);
      pend_v = 1'b0;
      last_d = '0;
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         step(g, v, data);
         chk("post-reset no rvalid", 64'(v), 64'd0);
      end
      issue("post-reset read", 1'b0, 8'h00, 64'h10, 64'h0, waits);
      chk("post-reset gnt from idle", 64'(waits), 64'd0);
      wait_resp("post-reset read", lat, data);
      chk("post-reset latency", 64'(lat), 64'(LAT));
      chk("post-reset rdata kept", data, 64'h1122334455667788);

      // Randomized traffic over a small pool of words at both ends of the array.
      for (int i = 0; i < 16; i++) begin
         pool = (i < 8) ? i : DEPTH - 16 + i;
         issue("rand preload", 1'b1, 8'hFF, 64'(pool) << 3, {$urandom, $urandom}, waits);
      end
      for (int n = 0; n < 1500; n++) begin
         pool = $urandom_range(0, 15);
         pool = (pool < 8) ? pool : DEPTH - 16 + pool;
         a = {$urandom, $urandom};
         a[12:3] = pool[9:0];
         case ($urandom_range(0, 3))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            default: b = 8'($urandom);
         endcase
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), b, a, {$urandom, $urandom});
         step(g, v, data);
      end
      drive(1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
      for (int k = 0; k < int'(LAT) + 2; k++) step(g, v, data);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/obi_sram_device.md
OBI_SRAM_DEVICE -- requirements
Module: obi_sram_device

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 64-bit memory words; power of two, 2..65536.
REQ-002 Parameter WAIT_CYCLES, default 2, read wait states between grant and response; range 1..15.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 req_i  input  1  host request valid.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 be_i  input  8  byte enables, bit n selects byte n of the word.
REQ-008 addr_i  input  64  byte address.
REQ-009 wdata_i  input  64  write data.
REQ-010 gnt_o  output  1  request accepted this cycle.
REQ-011 rvalid_o  output  1  read response valid, one-cycle pulse per accepted read.
REQ-012 rdata_o  output  64  read response data.

Function
REQ-013 Storage SHALL be DEPTH_WORDS x 64 bits, indexed by addr_i[log2(DEPTH_WORDS)+2:3]; addr_i[2:0] and higher bits ignored, so out-of-range addresses alias (wrap).
REQ-014 FSM states: IDLE, WAIT, RESP; at most one read outstanding.
REQ-015 gnt_o SHALL be combinational: req_i && (state == IDLE || state == RESP); gnt_o = 0 in WAIT.
REQ-016 Granted write: bytes with be_i[n] = 1 updated at the granting edge; be_i = 0x00 writes nothing; no response phase, FSM state unchanged by the write.
REQ-017 Granted read: word captured into rdata register at the granting edge; be_i ignored.
REQ-018 IDLE -> WAIT on granted read; counter loaded with WAIT_CYCLES-1.
REQ-019 WAIT: counter decrements each cycle; WAIT -> RESP when counter == 0; read latency = WAIT_CYCLES+1 cycles from grant edge to rvalid_o.
REQ-020 RESP: rvalid_o = 1 for exactly one cycle; rdata_o valid in that cycle.
REQ-021 RESP -> WAIT if a read is granted in the same cycle (back-to-back), else RESP -> IDLE; a write granted in RESP is committed and RESP -> IDLE.
REQ-022 Read-after-write: a read granted the cycle after a write to the same word SHALL return the written data.
REQ-023 rdata_o SHALL hold its last value when rvalid_o = 0.
REQ-024 req_i deasserted with no grant: no state or memory change.

Reset
REQ-025 rst_i asserted: state = IDLE, counter = 0, rvalid_o = 0, rdata_o = 0, gnt_o = 0 while rst_i is high; takes effect immediately, without a clock edge.
REQ-026 Reset mid-read SHALL discard the pending response; no rvalid_o is issued after reset release.
REQ-027 Memory contents SHALL NOT be reset.

Configuration
REQ-028 Macro OBI_DEV_WAIT_STATES_EN defined: WAIT state and counter present, behaviour per REQ-018..019.
REQ-029 Macro undefined: WAIT state and counter absent, WAIT_CYCLES ignored; granted read goes to RESP directly, rvalid_o one cycle after grant edge, gnt_o = req_i in all states.

Verification
REQ-030 Write addr 0x10, wdata 0x1122334455667788, be 0xFF; read addr 0x10 next cycle -> gnt_o same cycle, rvalid_o 3 cycles after grant edge (WAIT_CYCLES=2), rdata_o 0x1122334455667788.
REQ-031 Preload word 0x18 = 0; write be 0x0F wdata 0xFFFFFFFFFFFFFFFF; read -> rdata_o 0x00000000FFFFFFFF.
REQ-032 Two reads (0x0, 0x8) with req_i held -> second gnt_o in first RESP cycle, two rvalid_o pulses 3 cycles apart, gnt_o = 0 during WAIT.
REQ-033 DEPTH_WORDS=1024: write addr 0x2000 data 0xA5, read addr 0x0 -> rdata_o 0xA5 (alias).
REQ-034 Read granted, rst_i pulsed in WAIT -> rvalid_o stays 0, state IDLE, rdata_o 0, next read completes normally.
REQ-035 Build without OBI_DEV_WAIT_STATES_EN: read at 0x10 -> rvalid_o exactly 1 cycle after grant edge.
